pdu_gen_mc: RTL and testbench
=============================

// Module: pdu_gen_mc
// PURPOSE
//  Parametrised successor of the RX PDU generator. Pairs one metadata beat with each packet on the
//  streaming input, optionally byte-swaps every flit, and pushes flits and one descriptor per packet
//  into internal output FIFOs that feed the PCIe packet/metadata buffers. Adds byte-exact sizes,
//  per-packet drop, truncation at MAX_PKT_FLITS and drop/truncate counters.
// PARAMETERS
//  DATA_WIDTH        512   flit width in bits (multiple of 8); BYTES=DATA_WIDTH/8, EMPTY_W=$clog2(BYTES)
//  QUEUE_ID_WIDTH    13    width of pkt queue id carried in meta
//  BYTE_SWAP         1     1: out byte i = in byte BYTES-1-i; 0: pass-through
//  MAX_PKT_FLITS     24    longest packet forwarded; longer packets truncated
//  OUT_PKT_Q_DEPTH   64    packet FIFO depth (flits); must exceed 2*MAX_PKT_FLITS
//  OUT_META_Q_DEPTH  128   metadata FIFO depth (descriptors)
//  PKT_Q_AF_THRESH   OUT_PKT_Q_DEPTH-2*MAX_PKT_FLITS   pkt FIFO almost-full when occup > this
//  META_Q_AF_THRESH  OUT_META_Q_DEPTH-4                meta FIFO almost-full when occup > this
// PORTS
//  clk                  in   1            clock
//  rst                  in   1            synchronous reset, active high
//  in_sop/in_eop        in   1            start/end of packet, qualified by in_valid
//  in_data              in   DATA_WIDTH   flit payload
//  in_empty             in   EMPTY_W      unused bytes in eop flit
//  in_valid/in_ready    in/out 1          input flit handshake
//  in_meta_queue_id     in   QUEUE_ID_WIDTH  destination queue for next packet
//  in_meta_drop         in   1            1: consume next packet, emit nothing
//  in_meta_valid/ready  in/out 1          metadata handshake
//  out_pkt_data         out  DATA_WIDTH   flit to PCIe packet buffer
//  out_pkt_sop/eop      out  1            flit markers
//  out_pkt_valid/ready  out/in 1          packet FIFO read handshake
//  out_meta_queue_id    out  QUEUE_ID_WIDTH  descriptor queue id
//  out_meta_size_bytes  out  16           packet length in bytes
//  out_meta_size_flits  out  16           packet length in flits
//  out_meta_trunc       out  1            packet was truncated
//  out_meta_valid/ready out/in 1          descriptor FIFO read handshake
//  out_pkt_queue_occup  out  32           packet FIFO occupancy
//  out_meta_queue_occup out  32           meta FIFO occupancy
//  drop_cnt/trunc_cnt   out  32           packets dropped / truncated since reset
// BEHAVIOUR
//  - af = pkt_occup>PKT_Q_AF_THRESH | meta_occup>META_Q_AF_THRESH.
//  - FSM: WAIT_META (reset), FORWARD, DISCARD. Latched meta reg holds queue id and drop.
//  - in_meta_ready = !af & state==WAIT_META. in_ready: WAIT_META: !af & in_meta_valid;
//    FORWARD: !af; DISCARD: 1 (never stalls). Meta and first flit may be accepted same cycle.
//  - WAIT_META: flit accepted only with meta; meta used directly that cycle. drop=1 -> DISCARD
//    (or stay WAIT_META if flit has eop, drop_cnt++). Else write flit, -> FORWARD unless eop.
//  - First accepted flit of a packet always treated as sop (out sop=1); in_sop mid-packet ignored.
//  - FORWARD: each accepted flit written; flit_cnt++. eop -> descriptor, -> WAIT_META.
//    Accepting flit number MAX_PKT_FLITS without eop: write it with out eop=1, trunc=1,
//    trunc_cnt++, -> DISCARD.
//  - DISCARD: flits consumed, not written; in_eop -> WAIT_META; drop-path packet bumps drop_cnt at sop.
//  - Sizes: flits = count written; bytes = flits*BYTES - in_empty (truncated: flits*BYTES).
//    16-bit arithmetic, no wrap for legal MAX_PKT_FLITS*BYTES < 65536.
//  - Descriptor written in same cycle as the eop flit write; never written for dropped packets.
//  - One register stage into FIFOs: flit accepted in cycle N written at edge N+1; FIFO
//    read latency is on top. FIFO writes never see full (af guarantees headroom).
//  - Output reset values: all valids 0, in_ready/in_meta_ready 0 during rst, counters 0, FIFOs
//    flushed. Reset mid-packet discards partial state; next packet needs new meta.
//  - Counters saturate at 2^32-1.
// TESTING
//  1 meta q=5 + 1-flit pkt (sop&eop, empty=4, W=512) same cycle -> 1 flit sop&eop; desc q=5,60B,1 flit.
//  2 3-flit pkt, empty=0, out_pkt_ready=1 -> flits byte-reversed vs input; desc 192B, 3 flits.
//  3 meta drop=1 + 4-flit pkt, then normal pkt -> only 2nd pkt emitted; drop_cnt=1; no stall.
//  4 MAX_PKT_FLITS=4, 6-flit pkt -> 4 flits, 4th eop; desc 256B, trunc=1; trunc_cnt=1.
//  5 out_pkt_ready=0 until pkt occup>threshold -> in_ready,in_meta_ready drop; no flit lost.
//  6 rst asserted mid-packet for 1 cycle -> valids 0, occup 0; tail flits need fresh meta.

Source files
------------

// File: rtl/pdu_gen_mc_if.sv
// pdu_gen_mc_if: bus bundle for pdu_gen_mc.
//  in_*       : streaming flit input and per-packet metadata input (ready/valid)
//  out_pkt_*  : packet FIFO read side (flits toward the PCIe packet buffer)
//  out_meta_* : descriptor FIFO read side (toward the PCIe metadata buffer)
// slave is the generator's view, master is the view of the block driving it.
interface pdu_gen_mc_if #(
    parameter int unsigned DATA_WIDTH     = 512,
    parameter int unsigned QUEUE_ID_WIDTH = 13
);
    localparam int unsigned EMPTY_W = $clog2(DATA_WIDTH / 8);

    logic                      in_sop;
    logic                      in_eop;
    logic [DATA_WIDTH-1:0]     in_data;
    logic [EMPTY_W-1:0]        in_empty;
    logic                      in_valid;
    logic                      in_ready;
    logic [QUEUE_ID_WIDTH-1:0] in_meta_queue_id;
    logic                      in_meta_drop;
    logic                      in_meta_valid;
    logic                      in_meta_ready;

    logic [DATA_WIDTH-1:0]     out_pkt_data;
    logic                      out_pkt_sop;
    logic                      out_pkt_eop;
    logic                      out_pkt_valid;
    logic                      out_pkt_ready;
    logic [QUEUE_ID_WIDTH-1:0] out_meta_queue_id;
    logic [15:0]               out_meta_size_bytes;
    logic [15:0]               out_meta_size_flits;
    logic                      out_meta_trunc;
    logic                      out_meta_valid;
    logic                      out_meta_ready;

    modport master (
        output in_sop, in_eop, in_data, in_empty, in_valid,
        input  in_ready,
        output in_meta_queue_id, in_meta_drop, in_meta_valid,
        input  in_meta_ready,
        input  out_pkt_data, out_pkt_sop, out_pkt_eop, out_pkt_valid,
        output out_pkt_ready,
        input  out_meta_queue_id, out_meta_size_bytes, out_meta_size_flits,
        input  out_meta_trunc, out_meta_valid,
        output out_meta_ready
    );

    modport slave (
        input  in_sop, in_eop, in_data, in_empty, in_valid,
        output in_ready,
        input  in_meta_queue_id, in_meta_drop, in_meta_valid,
        output in_meta_ready,
        output out_pkt_data, out_pkt_sop, out_pkt_eop, out_pkt_valid,
        input  out_pkt_ready,
        output out_meta_queue_id, out_meta_size_bytes, out_meta_size_flits,
        output out_meta_trunc, out_meta_valid,
        input  out_meta_ready
    );
endinterface

// File: rtl/pdu_gen_mc.sv
// pdu_gen_mc: pairs one metadata beat with each input packet, optionally byte-swaps
// the flits, truncates at MAX_PKT_FLITS, drops on request, and queues flits plus one
// descriptor per forwarded packet into internal show-ahead FIFOs.
// Ports:
//  clk, rst               clock, synchronous active-high reset
//  bus (slave)            flit/meta input handshakes and FIFO read sides
//  out_pkt_queue_occup    packet FIFO occupancy (flits)
//  out_meta_queue_occup   descriptor FIFO occupancy
//  drop_cnt, trunc_cnt    saturating dropped / truncated packet counters
module pdu_gen_mc #(
    parameter int unsigned DATA_WIDTH       = 512,
    parameter int unsigned QUEUE_ID_WIDTH   = 13,
    parameter int unsigned BYTE_SWAP        = 1,
    parameter int unsigned MAX_PKT_FLITS    = 24,
    parameter int unsigned OUT_PKT_Q_DEPTH  = 64,
    parameter int unsigned OUT_META_Q_DEPTH = 128,
    parameter int unsigned PKT_Q_AF_THRESH  = OUT_PKT_Q_DEPTH - 2 * MAX_PKT_FLITS,
    parameter int unsigned META_Q_AF_THRESH = OUT_META_Q_DEPTH - 4
) (
    input  logic        clk,
    input  logic        rst,
    pdu_gen_mc_if.slave bus,
    output logic [31:0] out_pkt_queue_occup,
    output logic [31:0] out_meta_queue_occup,
    output logic [31:0] drop_cnt,
    output logic [31:0] trunc_cnt
);
    localparam int unsigned BYTES   = DATA_WIDTH / 8;
    localparam int unsigned SIZE_W  = 16;
    localparam int unsigned PKT_AW  = $clog2(OUT_PKT_Q_DEPTH);
    localparam int unsigned PKT_CW  = $clog2(OUT_PKT_Q_DEPTH + 1);
    localparam int unsigned META_AW = $clog2(OUT_META_Q_DEPTH);
    localparam int unsigned META_CW = $clog2(OUT_META_Q_DEPTH + 1);
    localparam int unsigned PKT_EW  = DATA_WIDTH + 2;
    localparam int unsigned META_EW = QUEUE_ID_WIDTH + 2 * SIZE_W + 1;

    typedef enum logic [1:0] {WAIT_META, FORWARD, DISCARD} state_t;

    state_t                    state_q, state_d;
    logic [SIZE_W-1:0]         flit_cnt_q, flit_cnt_d;
    logic [QUEUE_ID_WIDTH-1:0] meta_qid_q;

    logic                      in_ready_c, in_meta_ready_c;
    logic                      af;
    logic                      meta_latch, fwd_flit, wr_eop, wr_trunc, drop_inc, trunc_inc;
    logic [SIZE_W-1:0]         flit_num, bytes_full, size_bytes;
    logic [QUEUE_ID_WIDTH-1:0] cur_qid;
    logic [DATA_WIDTH-1:0]     flit_data;

    logic                      st_pkt_we, st_meta_we;
    logic [PKT_EW-1:0]         st_pkt;
    logic [META_EW-1:0]        st_meta;

    logic [PKT_EW-1:0]         pkt_mem [OUT_PKT_Q_DEPTH];
    logic [PKT_AW-1:0]         pkt_wp, pkt_rp;
    logic [PKT_CW-1:0]         pkt_occ;
    logic                      pkt_rd;
    logic [META_EW-1:0]        meta_mem [OUT_META_Q_DEPTH];
    logic [META_AW-1:0]        meta_wp, meta_rp;
    logic [META_CW-1:0]        meta_occ;
    logic                      meta_rd;

    // The first flit of a packet is always marked sop, so in_sop carries no information here.
    logic unused_in_sop;
    assign unused_in_sop = bus.in_sop;

    // Almost-full leaves room for the in-flight register stage plus a full packet.
    assign af = (32'(pkt_occ) > 32'(PKT_Q_AF_THRESH)) || (32'(meta_occ) > 32'(META_Q_AF_THRESH));

    assign bus.in_ready      = in_ready_c;
    assign bus.in_meta_ready = in_meta_ready_c;

    // Optional byte reversal of the flit payload.
    always_comb begin
        flit_data = bus.in_data;
        if (BYTE_SWAP != 0) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                flit_data[8*i +: 8] = bus.in_data[8*(BYTES-1-i) +: 8];
            end
        end
    end

    // Next-state, handshake and write decisions.
    always_comb begin
        state_d         = state_q;
        flit_cnt_d      = flit_cnt_q;
        in_ready_c      = 1'b0;
        in_meta_ready_c = 1'b0;
        meta_latch      = 1'b0;
        fwd_flit        = 1'b0;
        wr_eop          = 1'b0;
        wr_trunc        = 1'b0;
        drop_inc        = 1'b0;
        trunc_inc       = 1'b0;
        flit_num        = flit_cnt_q + SIZE_W'(1);
        cur_qid         = meta_qid_q;
        case (state_q)
            WAIT_META: begin
                // A flit is only taken together with its metadata; meta may also arrive alone.
                in_meta_ready_c = !rst && !af;
                in_ready_c      = !rst && !af && bus.in_meta_valid;
                flit_num        = SIZE_W'(1);
                cur_qid         = bus.in_meta_queue_id;
                if (bus.in_meta_valid && in_meta_ready_c) begin
                    meta_latch = 1'b1;
                    drop_inc   = bus.in_meta_drop;
                    if (bus.in_meta_drop) begin
                        if (!(bus.in_valid && bus.in_eop)) begin
                            state_d = DISCARD;
                        end
                    end else begin
                        fwd_flit   = bus.in_valid;
                        state_d    = FORWARD;
                        flit_cnt_d = '0;
                    end
                end
            end
            FORWARD: begin
                in_ready_c = !rst && !af;
                fwd_flit   = bus.in_valid && in_ready_c;
            end
            DISCARD: begin
                in_ready_c = !rst;
                if (bus.in_valid && in_ready_c && bus.in_eop) begin
                    state_d = WAIT_META;
                end
            end
            default: state_d = WAIT_META;
        endcase

        if (fwd_flit) begin
            if (bus.in_eop) begin
                wr_eop     = 1'b1;
                state_d    = WAIT_META;
                flit_cnt_d = '0;
            end else if (flit_num >= SIZE_W'(MAX_PKT_FLITS)) begin
                wr_eop     = 1'b1;
                wr_trunc   = 1'b1;
                trunc_inc  = 1'b1;
                state_d    = DISCARD;
                flit_cnt_d = '0;
            end else begin
                state_d    = FORWARD;
                flit_cnt_d = flit_num;
            end
        end
    end

    // Truncated packets report whole flits; otherwise the eop flit's empty bytes are removed.
    assign bytes_full = SIZE_W'(flit_num * SIZE_W'(BYTES));
    assign size_bytes = wr_trunc ? bytes_full : bytes_full - SIZE_W'(bus.in_empty);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_META;
            flit_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            flit_cnt_q <= flit_cnt_d;
        end
    end

    // Metadata latch, FIFO write stage and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_qid_q <= '0;
            st_pkt_we  <= 1'b0;
            st_pkt     <= '0;
            st_meta_we <= 1'b0;
            st_meta    <= '0;
            drop_cnt   <= '0;
            trunc_cnt  <= '0;
        end else begin
            if (meta_latch) begin
                meta_qid_q <= bus.in_meta_queue_id;
            end
            st_pkt_we  <= fwd_flit;
            st_meta_we <= wr_eop;
            if (fwd_flit) begin
                st_pkt <= {flit_num == SIZE_W'(1), wr_eop, flit_data};
            end
            if (wr_eop) begin
                st_meta <= {cur_qid, size_bytes, flit_num, wr_trunc};
            end
            if (drop_inc && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
            if (trunc_inc && trunc_cnt != '1) begin
                trunc_cnt <= trunc_cnt + 32'd1;
            end
        end
    end

    // FIFO storage (no reset; validity is tracked by the pointers).
    always_ff @(posedge clk) begin
        if (st_pkt_we) begin
            pkt_mem[pkt_wp] <= st_pkt;
        end
        if (st_meta_we) begin
            meta_mem[meta_wp] <= st_meta;
        end
    end

    assign pkt_rd  = (pkt_occ != '0) && bus.out_pkt_ready;
    assign meta_rd = (meta_occ != '0) && bus.out_meta_ready;

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_wp   <= '0;
            pkt_rp   <= '0;
            pkt_occ  <= '0;
            meta_wp  <= '0;
            meta_rp  <= '0;
            meta_occ <= '0;
        end else begin
            if (st_pkt_we) begin
                pkt_wp <= (pkt_wp == PKT_AW'(OUT_PKT_Q_DEPTH - 1)) ? '0 : pkt_wp + PKT_AW'(1);
            end
            if (pkt_rd) begin
                pkt_rp <= (pkt_rp == PKT_AW'(OUT_PKT_Q_DEPTH - 1)) ? '0 : pkt_rp + PKT_AW'(1);
            end
            case ({st_pkt_we, pkt_rd})
                2'b10:   pkt_occ <= pkt_occ + PKT_CW'(1);
                2'b01:   pkt_occ <= pkt_occ - PKT_CW'(1);
                default: pkt_occ <= pkt_occ;
            endcase
            if (st_meta_we) begin
                meta_wp <= (meta_wp == META_AW'(OUT_META_Q_DEPTH - 1)) ? '0 : meta_wp + META_AW'(1);
            end
            if (meta_rd) begin
                meta_rp <= (meta_rp == META_AW'(OUT_META_Q_DEPTH - 1)) ? '0 : meta_rp + META_AW'(1);
            end
            case ({st_meta_we, meta_rd})
                2'b10:   meta_occ <= meta_occ + META_CW'(1);
                2'b01:   meta_occ <= meta_occ - META_CW'(1);
                default: meta_occ <= meta_occ;
            endcase
        end
    end

    assign bus.out_pkt_valid  = pkt_occ != '0;
    assign bus.out_meta_valid = meta_occ != '0;
    assign {bus.out_pkt_sop, bus.out_pkt_eop, bus.out_pkt_data} = pkt_mem[pkt_rp];
    assign {bus.out_meta_queue_id, bus.out_meta_size_bytes, bus.out_meta_size_flits,
            bus.out_meta_trunc} = meta_mem[meta_rp];

    assign out_pkt_queue_occup  = 32'(pkt_occ);
    assign out_meta_queue_occup = 32'(meta_occ);
endmodule

// File: tb/tb_pdu_gen_mc.sv
// tb_pdu_gen_mc: scoreboard bench for pdu_gen_mc. Packets are generated with $urandom,
// a packet-level reference model queues the expected flits/descriptors, and a monitor
// pops and compares whenever the DUT hands over an output.
module tb_pdu_gen_mc;
    localparam int unsigned DW  = 64;
    localparam int unsigned QW  = 6;
    localparam int unsigned B   = DW / 8;
    localparam int unsigned EW  = $clog2(B);
    localparam int unsigned MAX = 4;
    localparam int unsigned PD  = 16;
    localparam int unsigned MD  = 8;

    typedef struct {
        logic [DW-1:0] data;
        bit            sop;
        bit            eop;
    } flit_t;

    typedef struct {
        logic [QW-1:0] qid;
        int            bytes;
        int            flits;
        bit            trunc;
    } desc_t;

    logic        clk;
    logic        rst;
    logic [31:0] out_pkt_queue_occup, out_meta_queue_occup, drop_cnt, trunc_cnt;

    pdu_gen_mc_if #(.DATA_WIDTH(DW), .QUEUE_ID_WIDTH(QW)) bus ();

    pdu_gen_mc #(
        .DATA_WIDTH(DW), .QUEUE_ID_WIDTH(QW), .BYTE_SWAP(1), .MAX_PKT_FLITS(MAX),
        .OUT_PKT_Q_DEPTH(PD), .OUT_META_Q_DEPTH(MD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .out_pkt_queue_occup(out_pkt_queue_occup),
        .out_meta_queue_occup(out_meta_queue_occup),
        .drop_cnt(drop_cnt),
        .trunc_cnt(trunc_cnt)
    );

    flit_t exp_flit_q[$];
    desc_t exp_desc_q[$];
    int    tests = 0;
    int    errors = 0;
    int    m_drop = 0;
    int    m_trunc = 0;
    int    rdy_mode = 0;
    bit    abort = 0;
    flit_t mon_f;
    desc_t mon_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] swap(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        for (int i = 0; i < int'(B); i++) r[8*i +: 8] = d[DW-8-8*i +: 8];
        return r;
    endfunction

    // Output readiness: 0 always ready, 1 random, 2 held off.
    initial begin
        bus.out_pkt_ready  = 1'b0;
        bus.out_meta_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: begin bus.out_pkt_ready = 1'b1; bus.out_meta_ready = 1'b1; end
                1: begin
                    bus.out_pkt_ready  = ($urandom_range(0, 3) != 0);
                    bus.out_meta_ready = ($urandom_range(0, 1) != 0);
                end
                default: begin bus.out_pkt_ready = 1'b0; bus.out_meta_ready = 1'b0; end
            endcase
        end
    end

    // Monitor: compare every handed-over flit and descriptor against the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.out_pkt_valid && bus.out_pkt_ready) begin
            if (exp_flit_q.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_flit: got data 0x%0h, expected no flit", bus.out_pkt_data);
            end else begin
                mon_f = exp_flit_q.pop_front();
                chk("flit_data", bus.out_pkt_data, mon_f.data);
                chk("flit_sop", bus.out_pkt_sop, mon_f.sop);
                chk("flit_eop", bus.out_pkt_eop, mon_f.eop);
            end
        end
        if (!rst && bus.out_meta_valid && bus.out_meta_ready) begin
            if (exp_desc_q.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_desc: got q=%0d bytes=%0d, expected no descriptor",
                         bus.out_meta_queue_id, bus.out_meta_size_bytes);
            end else begin
                mon_d = exp_desc_q.pop_front();
                chk("desc_qid", bus.out_meta_queue_id, mon_d.qid);
                chk("desc_bytes", bus.out_meta_size_bytes, mon_d.bytes);
                chk("desc_flits", bus.out_meta_size_flits, mon_d.flits);
                chk("desc_trunc", bus.out_meta_trunc, mon_d.trunc);
            end
        end
    end

    // Wait (bounded) for the selected input handshake; returns just after the accepting edge.
    task automatic wait_hs(input bit meta);
        int t = 0;
        bit r;
        while (1) begin
            @(negedge clk);
            r = meta ? bus.in_meta_ready : bus.in_ready;
            @(posedge clk);
            if (r) break;
            t++;
            if (t > 3000) begin
                tests++;
                errors++;
                $display("FAIL handshake_timeout: ready low for %0d cycles, expected high", t);
                abort = 1;
                break;
            end
        end
        #1;
    endtask

    task automatic send_pkt(input logic [QW-1:0] qid, input bit drop, input int len,
                            input logic [EW-1:0] empty, input bit meta_lead, input bit gaps);
        logic [DW-1:0] d[$];
        int            n;
        bit            tr;
        if (abort) return;
        for (int i = 0; i < len; i++) d.push_back({$urandom, $urandom});
        // Reference model at packet level.
        if (drop) begin
            m_drop++;
        end else begin
            tr = (len > int'(MAX));
            n  = tr ? int'(MAX) : len;
            for (int i = 0; i < n; i++) exp_flit_q.push_back('{swap(d[i]), i == 0, i == n - 1});
            exp_desc_q.push_back('{qid, tr ? n * int'(B) : n * int'(B) - int'(empty), n, tr});
            if (tr) m_trunc++;
        end
        bus.in_meta_queue_id = qid;
        bus.in_meta_drop     = drop;
        bus.in_meta_valid    = 1'b1;
        if (meta_lead) begin
            bus.in_valid = 1'b0;
            wait_hs(1);
            bus.in_meta_valid = 1'b0;
        end
        for (int i = 0; i < len && !abort; i++) begin
            if (gaps && i > 0) begin
                repeat ($urandom_range(0, 1)) begin
                    bus.in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            bus.in_data  = d[i];
            bus.in_sop   = (i == 0) || ($urandom_range(0, 7) == 0);
            bus.in_eop   = (i == len - 1);
            bus.in_empty = (i == len - 1) ? empty : EW'($urandom_range(0, B - 1));
            bus.in_valid = 1'b1;
            wait_hs(0);
            if (i == 0) bus.in_meta_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        bus.in_eop   = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_flit_q.size() != 0 || exp_desc_q.size() != 0) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("flits_outstanding", exp_flit_q.size(), 0);
        chk("descs_outstanding", exp_desc_q.size(), 0);
        chk("pkt_occup_idle", out_pkt_queue_occup, 0);
        chk("meta_occup_idle", out_meta_queue_occup, 0);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("trunc_cnt", trunc_cnt, m_trunc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                  = 1'b1;
        bus.in_sop           = 1'b0;
        bus.in_eop           = 1'b0;
        bus.in_data          = '0;
        bus.in_empty         = '0;
        bus.in_valid         = 1'b1;
        bus.in_meta_queue_id = '0;
        bus.in_meta_drop     = 1'b0;
        bus.in_meta_valid    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_in_meta_ready", bus.in_meta_ready, 0);
        chk("rst_pkt_valid", bus.out_pkt_valid, 0);
        chk("rst_meta_valid", bus.out_meta_valid, 0);
        chk("rst_pkt_occup", out_pkt_queue_occup, 0);
        chk("rst_meta_occup", out_meta_queue_occup, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_trunc_cnt", trunc_cnt, 0);
        @(posedge clk);
        #1;
        rst               = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_meta_valid = 1'b0;
        @(posedge clk);
        #1;

        // Single-flit packet with meta on the same cycle; 3-flit full packet.
        send_pkt(6'd5, 1'b0, 1, 3'd4, 1'b0, 1'b0);
        send_pkt(6'($urandom), 1'b0, 3, 3'd0, 1'b0, 1'b0);
        // Dropped packet followed by a normal one.
        send_pkt(6'($urandom), 1'b1, 4, 3'd2, 1'b0, 1'b0);
        send_pkt(6'($urandom), 1'b0, 2, 3'd7, 1'b0, 1'b0);
        drain();
        // Over-long packet is truncated; exactly MAX flits with eop is not.
        send_pkt(6'($urandom), 1'b0, 6, 3'd3, 1'b0, 1'b0);
        send_pkt(6'($urandom), 1'b0, 4, 3'd1, 1'b1, 1'b0);
        drain();

        // Back-pressure: hold the packet FIFO until almost-full throttles the input.
        rdy_mode = 2;
        fork
            begin
                for (int p = 0; p < 4; p++) send_pkt(6'($urandom), 1'b0, 3, 3'($urandom), 1'b0, 1'b0);
            end
            begin
                int t = 0;
                while (t < 2000) begin
                    @(negedge clk);
                    if (out_pkt_queue_occup > (PD - 2 * MAX)) break;
                    t++;
                end
                chk("af_reached", out_pkt_queue_occup > (PD - 2 * MAX), 1);
                chk("af_in_ready", bus.in_ready, 0);
                chk("af_in_meta_ready", bus.in_meta_ready, 0);
                repeat (5) @(negedge clk);
                chk("af_hold_in_ready", bus.in_ready, 0);
                rdy_mode = 1;
            end
        join
        drain();

        // Randomised traffic.
        rdy_mode = 1;
        for (int p = 0; p < 60 && !abort; p++) begin
            send_pkt(6'($urandom), $urandom_range(0, 4) == 0, $urandom_range(1, 7),
                     3'($urandom), 1'($urandom), 1'b1);
        end
        drain();

        // Reset in the middle of a packet.
        if (!abort) begin
            rdy_mode = 2;
            @(posedge clk);
            #1;
            bus.in_meta_queue_id = 6'd9;
            bus.in_meta_drop     = 1'b0;
            bus.in_meta_valid    = 1'b1;
            bus.in_data          = {$urandom, $urandom};
            bus.in_sop           = 1'b1;
            bus.in_eop           = 1'b0;
            bus.in_valid         = 1'b1;
            wait_hs(1);
            bus.in_meta_valid    = 1'b0;
            bus.in_sop           = 1'b0;
            bus.in_data          = {$urandom, $urandom};
            wait_hs(0);
            rst                  = 1'b1;
            bus.in_meta_valid    = 1'b1;
            bus.in_eop           = 1'b1;
            @(negedge clk);
            chk("midrst_in_ready", bus.in_ready, 0);
            chk("midrst_in_meta_ready", bus.in_meta_ready, 0);
            @(posedge clk);
            #1;
            rst               = 1'b0;
            bus.in_meta_valid = 1'b0;
            m_drop            = 0;
            m_trunc           = 0;
            @(negedge clk);
            chk("postrst_pkt_valid", bus.out_pkt_valid, 0);
            chk("postrst_meta_valid", bus.out_meta_valid, 0);
            chk("postrst_pkt_occup", out_pkt_queue_occup, 0);
            chk("postrst_meta_occup", out_meta_queue_occup, 0);
            chk("postrst_drop_cnt", drop_cnt, 0);
            for (int c = 0; c < 3; c++) begin
                chk("tail_needs_meta", bus.in_ready, 0);
                @(negedge clk);
            end
            chk("tail_not_written", out_pkt_queue_occup, 0);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_eop   = 1'b0;
            rdy_mode     = 1;
            send_pkt(6'd3, 1'b0, 2, 3'd5, 1'b0, 1'b0);
            send_pkt(6'd4, 1'b1, 1, 3'd0, 1'b1, 1'b0);
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
